// File: rtl/radiant_trig_pkg.sv
// Shared state encoding for the RADIANT trigger coincidence controller.
package radiant_trig_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_WINDOW  = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } trig_state_e;

endpackage

// File: rtl/radiant_trig_popcount.sv
// Purely combinational population count of an NUM_CH-bit channel vector.
module radiant_trig_popcount #(
  parameter  int NUM_CH = 24,
  localparam int CNT_W  = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH-1:0] i_vec,
  output logic [CNT_W-1:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      o_count = o_count + CNT_W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/radiant_trig_coinc_ctrl.sv
// N-of-M coincidence trigger with window, holdoff and busy extension.
// Optional TRIG_DEADTIME_CNT_EN adds a saturating FIRE/HOLDOFF clock counter.
module radiant_trig_coinc_ctrl
  import radiant_trig_pkg::*;
#(
  parameter  int NUM_CH = 24,
  parameter  int WIN_W  = 8,
  parameter  int HOLD_W = 16,
  localparam int THR_W  = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUM_CH-1:0] trig_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic              enable_i,
  input  logic [THR_W-1:0]  threshold_i,
  input  logic [WIN_W-1:0]  window_i,
  input  logic [HOLD_W-1:0] holdoff_i,
  input  logic              busy_i,
`ifdef TRIG_DEADTIME_CNT_EN
  input  logic              deadtime_clr_i,
  output logic [31:0]       deadtime_o,
`endif
  output logic              trig_o,
  output logic [NUM_CH-1:0] pattern_o,
  output logic [1:0]        state_o
);

  localparam int CNT_W = (WIN_W > HOLD_W) ? WIN_W : HOLD_W;

  trig_state_e       r_state;
  trig_state_e       w_state_next;
  logic [NUM_CH-1:0] r_pattern;
  logic [NUM_CH-1:0] r_pattern_out;
  logic [CNT_W-1:0]  r_cnt;
  logic [THR_W-1:0]  r_thr;
  logic              r_trig;

  logic [NUM_CH-1:0] w_hits;
  logic [NUM_CH-1:0] w_merged;
  logic [THR_W-1:0]  w_popcnt;
  logic [THR_W-1:0]  w_thr_live;
  logic [THR_W-1:0]  w_thr_eff;
  logic              w_any_hit;
  logic              w_reach;
  logic              w_cnt_zero;
  logic              w_hold_done;
  logic              w_open;
  logic              w_accum;
  logic              w_win_dec;
  logic              w_drop;
  logic              w_fire;
  logic              w_hold_dec;

  assign w_hits     = enable_i ? (trig_i & ~mask_i) : '0;
  assign w_merged   = r_pattern | w_hits;
  assign w_any_hit  = |w_hits;
  assign w_thr_live = (threshold_i == '0) ? THR_W'(1) : threshold_i;
  // Threshold is frozen when the window opens; IDLE compares against the live value.
  assign w_thr_eff  = (r_state == ST_IDLE) ? w_thr_live : r_thr;
  assign w_reach    = (w_popcnt >= w_thr_eff);
  assign w_cnt_zero = (r_cnt == '0);
  // FIRE plus holdoff_i HOLDOFF clocks of deadtime; the count reaches 0 on the exit edge.
  assign w_hold_done = (r_cnt <= CNT_W'(1)) && !busy_i;

  radiant_trig_popcount #(
    .NUM_CH (NUM_CH)
  ) u_popcount (
    .i_vec   (w_merged),
    .o_count (w_popcnt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_hit) w_state_next = w_reach ? ST_FIRE : ST_WINDOW;
      end
      ST_WINDOW: begin
        if (!enable_i)       w_state_next = ST_IDLE;
        else if (w_reach)    w_state_next = ST_FIRE;
        else if (w_cnt_zero) w_state_next = ST_IDLE;
      end
      ST_FIRE:    w_state_next = ST_HOLDOFF;
      ST_HOLDOFF: if (w_hold_done) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_open     = 1'b0;
    w_accum    = 1'b0;
    w_win_dec  = 1'b0;
    w_drop     = 1'b0;
    w_fire     = 1'b0;
    w_hold_dec = 1'b0;
    case (r_state)
      ST_IDLE:    w_open = w_any_hit;
      ST_WINDOW: begin
        w_accum   = (w_state_next != ST_IDLE);
        w_win_dec = (w_state_next == ST_WINDOW);
        w_drop    = (w_state_next == ST_IDLE);
      end
      ST_FIRE:    w_fire = 1'b1;
      ST_HOLDOFF: w_hold_dec = !w_cnt_zero;
      default:    ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pattern     <= '0;
      r_pattern_out <= '0;
      r_cnt         <= '0;
      r_thr         <= '0;
      r_trig        <= 1'b0;
    end else begin
      r_trig <= w_fire;
      if (w_fire) r_pattern_out <= r_pattern;

      if (w_open) begin
        r_pattern <= w_hits;
        r_thr     <= w_thr_live;
      end else if (w_accum) begin
        r_pattern <= w_merged;
      end else if (w_drop || w_fire) begin
        r_pattern <= '0;
      end

      if (w_open)                      r_cnt <= CNT_W'(window_i);
      else if (w_fire)                 r_cnt <= CNT_W'(holdoff_i);
      else if (w_win_dec || w_hold_dec) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign trig_o    = r_trig;
  assign pattern_o = r_pattern_out;
  assign state_o   = r_state;

`ifdef TRIG_DEADTIME_CNT_EN
  logic [31:0] r_deadtime;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_deadtime <= '0;
    end else if (deadtime_clr_i) begin
      r_deadtime <= '0;
    end else if ((r_state == ST_FIRE || r_state == ST_HOLDOFF) && (r_deadtime != 32'hFFFF_FFFF)) begin
      r_deadtime <= r_deadtime + 32'd1;
    end
  end

  assign deadtime_o = r_deadtime;
`endif

endmodule

// File: tb/tb_radiant_trig_coinc_ctrl.sv
// Scoreboard bench for radiant_trig_coinc_ctrl; expected triggers queued at stimulus time.
`timescale 1ns/1ps
module tb_radiant_trig_coinc_ctrl;

  localparam int NUM_CH = 24;
  localparam int WIN_W  = 8;
  localparam int HOLD_W = 16;
  localparam int THR_W  = $clog2(NUM_CH + 1);

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [NUM_CH-1:0] trig_i;
  logic [NUM_CH-1:0] mask_i;
  logic              enable_i;
  logic [THR_W-1:0]  threshold_i;
  logic [WIN_W-1:0]  window_i;
  logic [HOLD_W-1:0] holdoff_i;
  logic              busy_i;
  logic              trig_o;
  logic [NUM_CH-1:0] pattern_o;
  logic [1:0]        state_o;
`ifdef TRIG_DEADTIME_CNT_EN
  logic              deadtime_clr_i;
  logic [31:0]       deadtime_o;
`endif

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] pat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  radiant_trig_coinc_ctrl #(
    .NUM_CH (NUM_CH),
    .WIN_W  (WIN_W),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .trig_i         (trig_i),
    .mask_i         (mask_i),
    .enable_i       (enable_i),
    .threshold_i    (threshold_i),
    .window_i       (window_i),
    .holdoff_i      (holdoff_i),
    .busy_i         (busy_i),
`ifdef TRIG_DEADTIME_CNT_EN
    .deadtime_clr_i (deadtime_clr_i),
    .deadtime_o     (deadtime_o),
`endif
    .trig_o         (trig_o),
    .pattern_o      (pattern_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_n_i) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Scoreboard: every trig_o cycle must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1 && trig_o === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_trig: trig_o=1 at cycle %0d pattern_o=%h, required no trigger", cyc, pattern_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc !== e.cyc || pattern_o !== e.pat) begin
          n_fail++;
          $display("FAIL trig_match: got cycle %0d pattern %h, required cycle %0d pattern %h", cyc, pattern_o, e.cyc, e.pat);
        end else begin
          $display("trig cycle %0d pattern %h ok", cyc, pattern_o);
        end
      end
    end
  end

  task automatic step(input logic [NUM_CH-1:0] hits);
    trig_i = hits;
    @(posedge clk_i);
    #1;
    trig_i = '0;
  endtask

  task automatic expect_trig(input logic [NUM_CH-1:0] pat);
    exp_t e;
    e.cyc = cyc + 2;
    e.pat = pat;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (state_o !== 2'd0 && n < 200) begin
      step('0);
      n++;
    end
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: state_o=%0d, required 0", name, state_o);
    end
    step('0);
    step('0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_trig: %0d queued triggers not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; trig_i = '0; mask_i = '0; enable_i = 1'b1;
    threshold_i = 2; window_i = 4; holdoff_i = 3; busy_i = 1'b0;
`ifdef TRIG_DEADTIME_CNT_EN
    deadtime_clr_i = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks += 3;
    if (trig_o !== 1'b0)    begin n_fail++; $display("FAIL reset_trig: got %b required 0", trig_o); end
    if (pattern_o !== '0)   begin n_fail++; $display("FAIL reset_pattern: got %h required 0", pattern_o); end
    if (state_o !== 2'd0)   begin n_fail++; $display("FAIL reset_state: got %0d required 0", state_o); end
    $display("reset checked");
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_window_complete();
    threshold_i = 2; window_i = 4; holdoff_i = 3;
    step(24'h000008);
    step('0);
    step('0);
    expect_trig(24'h000088);
    step(24'h000080);
    n_checks++;
    if (state_o !== 2'd2) begin n_fail++; $display("FAIL basic_fire_state: got %0d required 2", state_o); end
    step('0);
    n_checks++;
    if (state_o !== 2'd3) begin n_fail++; $display("FAIL basic_holdoff_state: got %0d required 3", state_o); end
    step(24'hFFFFFF);
    step(24'hFFFFFF);
    n_checks++;
    if (state_o !== 2'd3) begin n_fail++; $display("FAIL basic_holdoff_last: got %0d required 3", state_o); end
    step(24'hFFFFFF);
    n_checks += 2;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL basic_holdoff_exit: got %0d required 0", state_o); end
    if (pattern_o !== 24'h000088) begin n_fail++; $display("FAIL basic_pattern_hold: got %h required 000088", pattern_o); end
    wait_idle("basic");
    $display("window_complete done");
  endtask

  task automatic test_window_expire();
    threshold_i = 2; window_i = 4;
    step(24'h000008);
    repeat (4) step('0);
    n_checks++;
    if (state_o !== 2'd1) begin n_fail++; $display("FAIL expire_last_window: got %0d required 1", state_o); end
    step('0);
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL expire_idle: got %0d required 0", state_o); end
    step(24'h000080);
    n_checks++;
    if (state_o !== 2'd1) begin n_fail++; $display("FAIL expire_reopen: got %0d required 1", state_o); end
    wait_idle("expire");
    $display("window_expire done");
  endtask

  task automatic test_expiry_edge();
    threshold_i = 2; window_i = 4;
    step(24'h000008);
    repeat (4) step('0);
    expect_trig(24'h000088);
    step(24'h000080);
    wait_idle("expiry_edge");
    $display("expiry_edge done");
  endtask

  task automatic test_zero_window();
    threshold_i = 2; window_i = 0;
    step(24'h000002);
    expect_trig(24'h000006);
    step(24'h000004);
    wait_idle("zero_win_fire");
    step(24'h000002);
    step('0);
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL zero_win_close: got %0d required 0", state_o); end
    step(24'h000004);
    n_checks++;
    if (state_o !== 2'd1) begin n_fail++; $display("FAIL zero_win_reopen: got %0d required 1", state_o); end
    wait_idle("zero_win_miss");
    $display("zero_window done");
  endtask

  task automatic test_threshold_limits();
    window_i = 2;
    threshold_i = 0;
    expect_trig(24'h000020);
    step(24'h000020);
    wait_idle("thr_zero");
    threshold_i = 24;
    step(24'hFFF000);
    expect_trig(24'hFFFFFF);
    step(24'h000FFF);
    wait_idle("thr_all");
    threshold_i = 25;
    step(24'hFFFFFF);
    step(24'hFFFFFF);
    wait_idle("thr_over");
    $display("threshold_limits done");
  endtask

  task automatic test_mask();
    threshold_i = 1; window_i = 4; mask_i = 24'h000008;
    step(24'h000008);
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL mask_ignored: got state %0d required 0", state_o); end
    expect_trig(24'h000010);
    step(24'h000010);
    wait_idle("mask");
    mask_i = '0;
    $display("mask done");
  endtask

  task automatic test_param_sampling();
    threshold_i = 3; window_i = 6;
    step(24'h000001);
    threshold_i = 1; window_i = 0;
    step(24'h000002);
    step('0);
    expect_trig(24'h000007);
    step(24'h000004);
    wait_idle("sampling");
    $display("param_sampling done");
  endtask

  task automatic test_enable_abort();
    threshold_i = 2; window_i = 6;
    step(24'h000001);
    enable_i = 1'b0;
    step(24'h000002);
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL enable_abort: got state %0d required 0", state_o); end
    enable_i = 1'b1;
    step(24'h000002);
    expect_trig(24'h000006);
    step(24'h000004);
    wait_idle("enable");
    $display("enable_abort done");
  endtask

  task automatic test_busy_holdoff();
    logic [NUM_CH-1:0] v;
    threshold_i = 1; window_i = 4; holdoff_i = 10; busy_i = 1'b1;
    v = NUM_CH'($urandom) | 24'h000001;
    expect_trig(v);
    step(v);
    for (int i = 1; i <= 21; i++) step(NUM_CH'($urandom) | 24'h000001);
    n_checks++;
    if (state_o !== 2'd3) begin n_fail++; $display("FAIL busy_extends: got state %0d required 3", state_o); end
    busy_i = 1'b0;
    step(24'hFFFFFF);
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL busy_release: got state %0d required 0", state_o); end
    wait_idle("busy");
    holdoff_i = 3;
    $display("busy_holdoff done");
  endtask

  task automatic test_reset_mid_window();
    threshold_i = 3; window_i = 6;
    step(24'h000003);
    step('0);
    #2;
    rst_n_i = 1'b0;
    #1;
    n_checks += 3;
    if (trig_o !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_trig: got %b required 0", trig_o); end
    if (pattern_o !== '0) begin n_fail++; $display("FAIL rst_mid_pattern: got %h required 0", pattern_o); end
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d required 0", state_o); end
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    step(24'h000004);
    wait_idle("rst_mid");
    $display("reset_mid_window done");
  endtask

`ifdef TRIG_DEADTIME_CNT_EN
  task automatic test_deadtime();
    threshold_i = 1; window_i = 4; holdoff_i = 5; busy_i = 1'b0;
    deadtime_clr_i = 1'b1;
    step('0);
    deadtime_clr_i = 1'b0;
    expect_trig(24'h000001);
    step(24'h000001);
    wait_idle("deadtime");
    n_checks++;
    if (deadtime_o !== 32'd6) begin n_fail++; $display("FAIL deadtime_count: got %0d required 6", deadtime_o); end
    deadtime_clr_i = 1'b1;
    step('0);
    deadtime_clr_i = 1'b0;
    n_checks++;
    if (deadtime_o !== 32'd0) begin n_fail++; $display("FAIL deadtime_clear: got %0d required 0", deadtime_o); end
    $display("deadtime done");
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_window_complete();
    test_window_expire();
    test_expiry_edge();
    test_zero_window();
    test_threshold_limits();
    test_mask();
    test_param_sampling();
    test_enable_abort();
    test_busy_holdoff();
    test_reset_mid_window();
`ifdef TRIG_DEADTIME_CNT_EN
    test_deadtime();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
